tx_dac_out: RTL

TX_DAC_OUT -- requirements
Module: tx_dac_out

---
 rtl/tx_dac_out_if.sv | 27 ++
 rtl/tx_dac_out.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/tx_dac_out_if.sv
// tx_dac_out_if -- sample stream bundle between the CP-insertion stage,
// the DAC output block and the DAC itself.
//   din_real/din_imag/din_valid : signed I/Q input samples and qualifier
//   dac_real/dac_imag/dac_valid : signed I/Q DAC samples and qualifier
// master : drives the input samples, observes the DAC samples
// slave  : the DAC output block (consumes input, produces DAC samples)
interface tx_dac_out_if #(
  parameter int DIN_W  = 18,
  parameter int DOUT_W = 12
);
  logic signed [DIN_W-1:0]  din_real;
  logic signed [DIN_W-1:0]  din_imag;
  logic                     din_valid;
  logic signed [DOUT_W-1:0] dac_real;
  logic signed [DOUT_W-1:0] dac_imag;
  logic                     dac_valid;

  modport master (
    output din_real, din_imag, din_valid,
    input  dac_real, dac_imag, dac_valid
  );

  modport slave (
    input  din_real, din_imag, din_valid,
    output dac_real, dac_imag, dac_valid
  );
endinterface

// File: rtl/tx_dac_out.sv
// tx_dac_out -- rounds/saturates I/Q samples to DAC width, buffers them in
// an elastic FIFO and streams them to the DAC once enough are buffered
// (or after the input has gone quiet).
//   clk        : single rising-edge clock
//   rst_n      : asynchronous active-low reset
//   bus        : tx_dac_out_if slave (din_* in, dac_* out)
//   fifo_ovf   : sticky overflow flag, cleared only by reset
//   fifo_level : current FIFO occupancy
//
// state  | meaning
// IDLE   | buffering; DAC held at mid-scale (zero), waiting to prime/flush
// STREAM | popping one FIFO entry per cycle to the DAC until empty
module tx_dac_out #(
  parameter int DIN_W      = 18,
  parameter int DOUT_W     = 12,
  parameter int FIFO_DEPTH = 16,
  parameter int PRIME_LVL  = 8,
  parameter int FLUSH_CYC  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  tx_dac_out_if.slave                   bus,
  output logic                          fifo_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int SH = DIN_W - DOUT_W;
  localparam int SW = DIN_W + 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FLUSH_CYC + 1);

  localparam logic signed [SW-1:0] RND   = SW'(2 ** (SH - 1));
  localparam logic signed [SW-1:0] MAX_O = SW'((2 ** (DOUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_O = SW'(-(2 ** (DOUT_W - 1)));
  localparam logic [AW:0]          DEPTH_L = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0]        FLUSH_L = CW'(FLUSH_CYC);

  typedef enum logic {ST_IDLE, ST_STREAM} state_t;

  state_t state, state_nxt;

  logic signed [DOUT_W-1:0] s1_real, s1_imag;
  logic                     s1_valid;

  logic [2*DOUT_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       idle_cnt;
  logic                full, rd_en, wr_en;

  // Round half-up then saturate; the sum carries one extra bit so the
  // rounding offset cannot wrap a full-scale positive input.
  function automatic logic signed [DOUT_W-1:0] round_sat(input logic signed [DIN_W-1:0] x);
    logic signed [SW-1:0] sum;
    logic signed [SW-1:0] shr;
    sum = {x[DIN_W-1], x} + RND;
    shr = sum >>> SH;
    if (shr > MAX_O)
      return DOUT_W'(MAX_O);
    else if (shr < MIN_O)
      return DOUT_W'(MIN_O);
    else
      return DOUT_W'(shr);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_real  <= '0;
      s1_imag  <= '0;
      s1_valid <= 1'b0;
    end else begin
      s1_real  <= round_sat(bus.din_real);
      s1_imag  <= round_sat(bus.din_imag);
      s1_valid <= bus.din_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:
        if (int'(fifo_level) >= PRIME_LVL ||
            (idle_cnt == FLUSH_L && fifo_level != '0))
          state_nxt = ST_STREAM;
      ST_STREAM:
        if (fifo_level == '0)
          state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Popping on the transition edge itself keeps the occupancy pinned at the
  // prime level during continuous input instead of overshooting by one.
  assign full  = (fifo_level == DEPTH_L);
  assign rd_en = (state_nxt == ST_STREAM) && (fifo_level != '0);
  assign wr_en = s1_valid && (!full || rd_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (bus.din_valid || state != ST_IDLE || state_nxt != ST_IDLE) begin
      idle_cnt <= '0;
    end else if (idle_cnt != FLUSH_L) begin
      idle_cnt <= idle_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= {s1_real, s1_imag};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      fifo_ovf   <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
        2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (s1_valid && full && !rd_en) fifo_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dac_real  <= '0;
      bus.dac_imag  <= '0;
      bus.dac_valid <= 1'b0;
    end else if (rd_en) begin
      bus.dac_real  <= mem[rd_ptr][2*DOUT_W-1:DOUT_W];
      bus.dac_imag  <= mem[rd_ptr][DOUT_W-1:0];
      bus.dac_valid <= 1'b1;
    end else begin
      bus.dac_real  <= '0;
      bus.dac_imag  <= '0;
      bus.dac_valid <= 1'b0;
    end
  end

endmodule
